// File: rtl/lcd_bus_driver.sv
// HD44780 4-bit bus executor: sends {RS,RW,DB7..DB0} as two enable-strobed nibbles, then holds busy for the execution time.
// Optional macro LCD_POWERON_INIT_EN adds the power-on wait and 3,3,3,2 init nibble sequence ahead of IDLE.
module lcd_bus_driver #(
    parameter int unsigned T_SETUP     = 32'd2,
    parameter int unsigned T_E_HIGH    = 32'd12,
    parameter int unsigned T_NIB_GAP   = 32'd50,
    parameter int unsigned T_EXEC      = 32'd2000,
    parameter int unsigned T_EXEC_LONG = 32'd82000,
    parameter int unsigned T_PWR       = 32'd750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       next_instruction,
    input  logic [9:0] db,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_d,
    output logic       sf_ce0
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SETUP_HI   = 4'd1;
    localparam logic [3:0] S_E_HI       = 4'd2;
    localparam logic [3:0] S_GAP        = 4'd3;
    localparam logic [3:0] S_SETUP_LO   = 4'd4;
    localparam logic [3:0] S_E_LO       = 4'd5;
    localparam logic [3:0] S_EXEC_WAIT  = 4'd6;
    localparam logic [3:0] S_PWR_WAIT   = 4'd7;
    localparam logic [3:0] S_INIT_SETUP = 4'd8;
    localparam logic [3:0] S_INIT_E     = 4'd9;
    localparam logic [3:0] S_INIT_WAIT  = 4'd10;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counters hold (duration - 1) at most, so the largest duration sets the width.
    localparam int unsigned CNT_MAX = max2(max2(max2(T_SETUP, T_E_HIGH), max2(T_NIB_GAP, T_EXEC)),
                                           max2(T_EXEC_LONG, max2(T_PWR, 32'd205000)));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_rs;
    logic             r_e;
    logic [3:0]       r_d;
    logic [3:0]       r_lo;
    logic             r_long;

    logic [3:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_dur;
    logic             w_last;
    logic             w_busy_nxt;
    logic             w_rs_nxt;
    logic             w_e_nxt;
    logic [3:0]       w_d_nxt;
    logic [3:0]       w_lo_nxt;
    logic             w_long_nxt;
    logic             w_unused;

`ifdef LCD_POWERON_INIT_EN
    logic [1:0] r_idx;
    logic [1:0] w_idx_nxt;
    localparam logic [3:0]  RST_STATE = S_PWR_WAIT;
    localparam logic        RST_BUSY  = 1'b1;
`else
    localparam logic [3:0]  RST_STATE = S_IDLE;
    localparam logic        RST_BUSY  = 1'b0;
`endif

    // RW is accepted in the word but this block only ever writes.
    assign w_unused = db[8];
    assign w_last   = (r_cnt == w_dur);

    // Last count value of the current timed state.
    always_comb begin
        w_dur = {CNT_W{1'b0}};
        case (r_state)
            S_SETUP_HI, S_SETUP_LO: w_dur = CNT_W'(T_SETUP - 32'd1);
            S_E_HI, S_E_LO:         w_dur = CNT_W'(T_E_HIGH - 32'd1);
            S_GAP:                  w_dur = CNT_W'(T_NIB_GAP - 32'd1);
            S_EXEC_WAIT:            w_dur = r_long ? CNT_W'(T_EXEC_LONG - 32'd1) : CNT_W'(T_EXEC - 32'd1);
`ifdef LCD_POWERON_INIT_EN
            S_PWR_WAIT:             w_dur = CNT_W'(T_PWR - 32'd1);
            S_INIT_SETUP:           w_dur = CNT_W'(T_SETUP - 32'd1);
            S_INIT_E:               w_dur = CNT_W'(T_E_HIGH - 32'd1);
            S_INIT_WAIT: begin
                case (r_idx)
                    2'd0:    w_dur = CNT_W'(32'd204999);
                    2'd1:    w_dur = CNT_W'(32'd4999);
                    default: w_dur = CNT_W'(32'd1999);
                endcase
            end
`endif
            default:                w_dur = {CNT_W{1'b0}};
        endcase
    end

    // Next-state and next-output decode; outputs change only on state transitions.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_rs_nxt    = r_rs;
        w_e_nxt     = r_e;
        w_d_nxt     = r_d;
        w_lo_nxt    = r_lo;
        w_long_nxt  = r_long;
        w_cnt_nxt   = w_last ? {CNT_W{1'b0}} : (r_cnt + {{(CNT_W-1){1'b0}}, 1'b1});
`ifdef LCD_POWERON_INIT_EN
        w_idx_nxt   = r_idx;
`endif
        case (r_state)
            S_IDLE: begin
                if (next_instruction) begin
                    w_state_nxt = S_SETUP_HI;
                    w_busy_nxt  = 1'b1;
                    w_rs_nxt    = db[9];
                    w_d_nxt     = db[7:4];
                    w_lo_nxt    = db[3:0];
                    w_long_nxt  = (db == 10'h001) || (db[9:1] == 9'h001);
                    w_e_nxt     = 1'b0;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_e_nxt     = 1'b0;
                end
            end
            S_SETUP_HI: begin
                if (w_last) begin w_state_nxt = S_E_HI; w_e_nxt = 1'b1; end
                else        begin w_e_nxt = 1'b0; end
            end
            S_E_HI: begin
                if (w_last) begin w_state_nxt = S_GAP; w_e_nxt = 1'b0; end
                else        begin w_e_nxt = 1'b1; end
            end
            S_GAP: begin
                if (w_last) begin w_state_nxt = S_SETUP_LO; w_d_nxt = r_lo; end
                else        begin w_e_nxt = 1'b0; end
            end
            S_SETUP_LO: begin
                if (w_last) begin w_state_nxt = S_E_LO; w_e_nxt = 1'b1; end
                else        begin w_e_nxt = 1'b0; end
            end
            S_E_LO: begin
                if (w_last) begin w_state_nxt = S_EXEC_WAIT; w_e_nxt = 1'b0; end
                else        begin w_e_nxt = 1'b1; end
            end
            S_EXEC_WAIT: begin
                if (w_last) begin w_state_nxt = S_IDLE; w_busy_nxt = 1'b0; end
                else        begin w_e_nxt = 1'b0; end
            end
`ifdef LCD_POWERON_INIT_EN
            S_PWR_WAIT: begin
                if (w_last) begin w_state_nxt = S_INIT_SETUP; w_d_nxt = 4'h3; w_idx_nxt = 2'd0; end
                else        begin w_e_nxt = 1'b0; end
            end
            S_INIT_SETUP: begin
                if (w_last) begin w_state_nxt = S_INIT_E; w_e_nxt = 1'b1; end
                else        begin w_e_nxt = 1'b0; end
            end
            S_INIT_E: begin
                if (w_last) begin w_state_nxt = S_INIT_WAIT; w_e_nxt = 1'b0; end
                else        begin w_e_nxt = 1'b1; end
            end
            S_INIT_WAIT: begin
                if (w_last && (r_idx == 2'd3)) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (w_last) begin
                    w_state_nxt = S_INIT_SETUP;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_d_nxt     = (r_idx == 2'd2) ? 4'h2 : 4'h3;
                end else begin
                    w_e_nxt     = 1'b0;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_e_nxt     = 1'b0;
            end
        endcase
    end

    // State, counter and registered LCD outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RST_STATE;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= RST_BUSY;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
            r_d     <= 4'h0;
            r_lo    <= 4'h0;
            r_long  <= 1'b0;
`ifdef LCD_POWERON_INIT_EN
            r_idx   <= 2'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_rs    <= w_rs_nxt;
            r_e     <= w_e_nxt;
            r_d     <= w_d_nxt;
            r_lo    <= w_lo_nxt;
            r_long  <= w_long_nxt;
`ifdef LCD_POWERON_INIT_EN
            r_idx   <= w_idx_nxt;
`endif
        end
    end

    assign busy   = r_busy;
    assign lcd_rs = r_rs;
    assign lcd_e  = r_e;
    assign lcd_d  = r_d;
    assign lcd_rw = 1'b0;
    assign sf_ce0 = 1'b1;

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
- LCD-side executor for the 10-bit instruction words {RS, RW, DB7..DB0} issued by the configuration/sequencing FSM.
- Accepts one word per next_instruction strobe and raises busy while the word is in flight.
- Drives the word to the character LCD over the 4-bit interface: upper nibble first, then lower nibble.
- Holds busy until the HD44780 execution time for that instruction has elapsed.

Parameters:
- T_SETUP, 2: cycles data/RS are stable before lcd_e rises (40 ns at 50 MHz).
- T_E_HIGH, 12: cycles lcd_e is held high per nibble (240 ns).
- T_NIB_GAP, 50: cycles from end of upper-nibble pulse to start of lower-nibble setup (1 us).
- T_EXEC, 2000: post-instruction wait for normal instructions (40 us).
- T_EXEC_LONG, 82000: post-instruction wait for Clear Display / Return Home (1.64 ms).
- T_PWR, 750000: power-on wait before init nibbles (15 ms); used only with the optional feature.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset.
- next_instruction  in  1  one-cycle strobe: db holds a valid instruction word.
- db  in  10  instruction word: [9]=RS, [8]=RW, [7:0]=DB7..DB0.
- busy  out  1  high while a word or the init sequence is executing.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; constant 0.
- lcd_e  out  1  LCD enable strobe.
- lcd_d  out  4  LCD data bus DB7..DB4 (SF_D[11:8]).
- sf_ce0  out  1  StrataFlash chip enable; constant 1 to release the shared bus.

Behaviour:
- Synchronous active-low reset, applied on the clk edge where reset==0, valid in any state, including mid-pulse or mid-wait.
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=4'h0, sf_ce0=1, busy=0 (busy=1 if LCD_POWERON_INIT_EN), state IDLE (PWR_WAIT with macro). All counters cleared.
- Accept rule: a word is captured only on an edge where state==IDLE and next_instruction==1. Strobes while busy==1 are ignored (not queued).
- All outputs are registered. The cycle after acceptance: busy=1, lcd_rs=db[9], lcd_d=db[7:4], lcd_e=0.
- db[8] is ignored; the block supports writes only, so lcd_rw stays 0.
- States:
  - IDLE -> SETUP_HI on accept.
  - SETUP_HI: T_SETUP cycles, then E_HI.
  - E_HI: lcd_e=1 for T_E_HIGH cycles, then GAP.
  - GAP: lcd_e=0, data held, for T_NIB_GAP cycles; on exit lcd_d=db[3:0], then SETUP_LO.
  - SETUP_LO: T_SETUP cycles, then E_LO.
  - E_LO: lcd_e=1 for T_E_HIGH cycles, then EXEC_WAIT.
  - EXEC_WAIT: lcd_e=0 for T_EXEC or T_EXEC_LONG cycles, then IDLE with busy=0.
- Long-wait select, decoded from the captured word:
  - Clear Display: word==10'h001.
  - Return Home: word[9:1]==9'h001.
  - Every other word uses T_EXEC.
- Busy duration: exactly 2*T_SETUP + 2*T_E_HIGH + T_NIB_GAP + wait cycles. With defaults: 2078 cycles normal, 82078 cycles long.
- Earliest next accept is on the first cycle busy==0, so back-to-back issue is possible.
- lcd_rs and lcd_d are stable across the whole E-high window and for at least one cycle after lcd_e falls.
- Counter widths: sized for the largest parameter in use (20 bits with defaults). Counters saturate nowhere; each reloads on state entry.
- next_instruction asserted in the same cycle reset==0: ignored; reset wins.

Optional Feature:
Macro: LCD_POWERON_INIT_EN
- Defined: after reset release, busy stays 1 and the block runs the HD44780 4-bit power-on sequence, with lcd_rs=0 throughout:
  - wait T_PWR;
  - nibble 0x3 (T_SETUP + T_E_HIGH pulse), wait 205000;
  - nibble 0x3, wait 5000;
  - nibble 0x3, wait 2000;
  - nibble 0x2, wait 2000;
  - enter IDLE with busy=0.
- Strobes during init are ignored.
- Undefined: the init states are absent; busy=0 from reset and IDLE is entered directly.

Test Plan:
- Release reset, pulse next_instruction with db=10'h028 -> lcd_d=0x2 then 0x0, two lcd_e pulses of 12 cycles each with rs=0, busy high exactly 2078 cycles.
- db=10'h001 (Clear Display) -> busy high exactly 82078 cycles; nibbles 0x0, 0x1.
- db=10'h248 (data write 'H') -> lcd_rs=1 during both pulses, nibbles 0x4 then 0x8, rw=0, busy 2078 cycles.
- Second strobe (db=10'h00C) 100 cycles into a busy word -> ignored; only one pair of lcd_e pulses. A strobe on the first busy==0 cycle is accepted.
- Assert reset during E_HI of the lower nibble -> next cycle lcd_e=0, lcd_d=0, busy=0 (macro off), and a new word is accepted normally afterwards.
- With LCD_POWERON_INIT_EN -> busy=1 from reset; first lcd_e rise after 750002 cycles; four init pulses with nibbles 3,3,3,2; busy falls after the final 2000-cycle wait.
